// File: rtl/ovc_status_tracker_pkg.sv
// Shared definitions for the output-VC status tracker and its consumers.
//   cr_width     : credit counter width needed to hold 0..depth inclusive
//   ovc_status_t : per-VC status bundle reused by the VC/switch allocators
package ovc_status_tracker_pkg;

  function automatic int unsigned cr_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic assigned;
    logic full;
    logic nearly_full;
    logic avb;
  } ovc_status_t;

endpackage

// File: rtl/ovc_credit_counter.sv
// Downstream credit counter for a single output VC.
//   clk, reset  : router clock, synchronous active-high reset (count -> B)
//   inc         : credit returned from downstream
//   dec         : flit sent on this VC (consumes one credit)
//   count       : credits currently available downstream
//   full        : count == 0
//   nearly_full : count == 1
//   err         : this cycle's update would underflow/overflow (combinational pulse)
module ovc_credit_counter
  import ovc_status_tracker_pkg::*;
#(
  parameter int unsigned B = 4,
  localparam int unsigned CRw = cr_width(B)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic           dec,
  output logic [CRw-1:0] count,
  output logic           full,
  output logic           nearly_full,
  output logic           err
);

  localparam logic [CRw-1:0] MaxCount = CRw'(B);

  logic [CRw-1:0] count_q, count_d;

  // Simultaneous inc and dec cancel out, even at the limits.
  always_comb begin
    count_d = count_q;
    err     = 1'b0;
    if (inc && !dec) begin
      if (count_q == MaxCount) begin
        err = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec && !inc) begin
      if (count_q == '0) begin
        err = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MaxCount;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign full        = (count_q == '0);
  assign nearly_full = (count_q == CRw'(1));

endmodule

// File: rtl/ovc_status_tracker.sv
// Per-output-port output-VC bookkeeping: assignment flags and downstream
// credit counts, decoded into masks the VC allocator ANDs with its
// class-permitted VC list.
//   clk, reset          : router clock, synchronous active-high reset
//   ovc_allocated_in    : one-hot VC granted to a new packet this cycle
//   flit_sent_in        : a flit leaves this port this cycle
//   flit_vc_in          : one-hot VC of the sent flit
//   tail_sent_in        : sent flit is a tail / single-flit packet
//   credit_in           : credit returns, any subset of VCs
//   ovc_avb_out         : VC unassigned with credits > 0
//   ovc_is_assigned_out : VC owned by a packet
//   ovc_full_out        : no credits left
//   ovc_nearly_full_out : exactly one credit left
//   credit_err_out      : sticky protocol error, cleared only by reset
// All outputs decode registered state only (one-cycle latency).
module ovc_status_tracker
  import ovc_status_tracker_pkg::*;
#(
  parameter int unsigned V = 4,
  parameter int unsigned B = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [V-1:0] ovc_allocated_in,
  input  logic         flit_sent_in,
  input  logic [V-1:0] flit_vc_in,
  input  logic         tail_sent_in,
  input  logic [V-1:0] credit_in,
  output logic [V-1:0] ovc_avb_out,
  output logic [V-1:0] ovc_is_assigned_out,
  output logic [V-1:0] ovc_full_out,
  output logic [V-1:0] ovc_nearly_full_out,
  output logic         credit_err_out
);

  localparam int unsigned CRw = cr_width(B);

  logic [V-1:0]   dec, rel;
  logic [V-1:0]   cnt_err, cnt_full, cnt_nearly_full, has_credit;
  logic [CRw-1:0] count [V];

  logic [V-1:0] assigned_q, assigned_d;
  logic         err_q, err_d, err_event;

  ovc_status_t  status [V];

  assign dec = {V{flit_sent_in}} & flit_vc_in;
  assign rel = dec & {V{tail_sent_in}};

  for (genvar v = 0; v < V; v++) begin : gen_vc
    ovc_credit_counter #(
      .B (B)
    ) u_credit_counter (
      .clk         (clk),
      .reset       (reset),
      .inc         (credit_in[v]),
      .dec         (dec[v]),
      .count       (count[v]),
      .full        (cnt_full[v]),
      .nearly_full (cnt_nearly_full[v]),
      .err         (cnt_err[v])
    );
    assign has_credit[v] = |count[v];
  end

  // Alloc wins over release so a new packet can take the VC back-to-back.
  assign assigned_d = (assigned_q & ~rel) | ovc_allocated_in;

  always_comb begin
    err_event = 1'b0;
    if (|cnt_err)                                     err_event = 1'b1;
    if (flit_sent_in && !$onehot(flit_vc_in))         err_event = 1'b1;
    if (!$onehot0(ovc_allocated_in))                  err_event = 1'b1;
    if (|(ovc_allocated_in & assigned_q & ~rel))      err_event = 1'b1;
    // Sending on an unowned VC still consumes the credit in the counter.
    if (|(dec & ~assigned_q))                         err_event = 1'b1;
    err_d = err_q | err_event;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assigned_q <= '0;
      err_q      <= 1'b0;
    end else begin
      assigned_q <= assigned_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    for (int v = 0; v < V; v++) begin
      status[v].assigned    = assigned_q[v];
      status[v].full        = cnt_full[v];
      status[v].nearly_full = cnt_nearly_full[v];
      status[v].avb         = ~assigned_q[v] & has_credit[v];
    end
  end

  always_comb begin
    ovc_avb_out         = '0;
    ovc_is_assigned_out = '0;
    ovc_full_out        = '0;
    ovc_nearly_full_out = '0;
    for (int v = 0; v < V; v++) begin
      ovc_avb_out[v]         = status[v].avb;
      ovc_is_assigned_out[v] = status[v].assigned;
      ovc_full_out[v]        = status[v].full;
      ovc_nearly_full_out[v] = status[v].nearly_full;
    end
  end

  assign credit_err_out = err_q;

endmodule

// File: tb/tb_ovc_status_tracker.sv
module tb_ovc_status_tracker;

  localparam int unsigned V = 4;
  localparam int unsigned B = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [V-1:0] ovc_allocated_in;
  logic         flit_sent_in;
  logic [V-1:0] flit_vc_in;
  logic         tail_sent_in;
  logic [V-1:0] credit_in;
  logic [V-1:0] ovc_avb_out;
  logic [V-1:0] ovc_is_assigned_out;
  logic [V-1:0] ovc_full_out;
  logic [V-1:0] ovc_nearly_full_out;
  logic         credit_err_out;

  ovc_status_tracker #(
    .V (V),
    .B (B)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .ovc_allocated_in    (ovc_allocated_in),
    .flit_sent_in        (flit_sent_in),
    .flit_vc_in          (flit_vc_in),
    .tail_sent_in        (tail_sent_in),
    .credit_in           (credit_in),
    .ovc_avb_out         (ovc_avb_out),
    .ovc_is_assigned_out (ovc_is_assigned_out),
    .ovc_full_out        (ovc_full_out),
    .ovc_nearly_full_out (ovc_nearly_full_out),
    .credit_err_out      (credit_err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: credits per VC, ownership per VC, sticky error.
  int m_cnt [V];
  bit m_asg [V];
  bit m_err;

  // Traffic generator state for legal random traffic.
  int rem  [V];  // flits left in the packet owning the VC (0 = free)
  int pend [V];  // flits sent downstream whose credit has not come back

  typedef struct {
    logic [V-1:0] alloc;
    logic         sent;
    logic [V-1:0] vc;
    logic         tail;
    logic [V-1:0] credit;
    logic [V-1:0] avb;
    logic [V-1:0] asg;
    logic [V-1:0] full;
    logic [V-1:0] nf;
    logic         err;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [V-1:0] got, input logic [V-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_cnt[v] = B;
      m_asg[v] = 1'b0;
      rem[v]   = 0;
      pend[v]  = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [V-1:0] a, input logic s, input logic [V-1:0] fv,
                            input logic t, input logic [V-1:0] c);
    if (s && $countones(fv) != 1) m_err = 1'b1;
    if ($countones(a) > 1) m_err = 1'b1;
    for (int v = 0; v < V; v++) begin
      bit sent_here, released;
      sent_here = s && fv[v];
      released  = sent_here && t;
      if (sent_here && !c[v]) begin
        if (m_cnt[v] == 0) m_err = 1'b1;
        else m_cnt[v] = m_cnt[v] - 1;
      end else if (c[v] && !sent_here) begin
        if (m_cnt[v] == int'(B)) m_err = 1'b1;
        else m_cnt[v] = m_cnt[v] + 1;
      end
      if (sent_here && !m_asg[v]) m_err = 1'b1;
      if (a[v] && m_asg[v] && !released) m_err = 1'b1;
      m_asg[v] = (m_asg[v] && !released) || a[v];
    end
  endtask

  task automatic check_model(input string name);
    logic [V-1:0] e_avb, e_asg, e_full, e_nf;
    for (int v = 0; v < V; v++) begin
      e_asg[v]  = m_asg[v];
      e_avb[v]  = !m_asg[v] && (m_cnt[v] > 0);
      e_full[v] = (m_cnt[v] == 0);
      e_nf[v]   = (m_cnt[v] == 1);
    end
    check({name, ".avb"}, ovc_avb_out, e_avb);
    check({name, ".asg"}, ovc_is_assigned_out, e_asg);
    check({name, ".full"}, ovc_full_out, e_full);
    check({name, ".nf"}, ovc_nearly_full_out, e_nf);
    check1({name, ".err"}, credit_err_out, m_err);
  endtask

  task automatic apply(input logic [V-1:0] a, input logic s, input logic [V-1:0] fv,
                       input logic t, input logic [V-1:0] c);
    ovc_allocated_in = a;
    flit_sent_in     = s;
    flit_vc_in       = fv;
    tail_sent_in     = t;
    credit_in        = c;
    model_step(a, s, fv, t, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply('0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rst();
    reset            = 1'b1;
    ovc_allocated_in = '0;
    flit_sent_in     = 1'b0;
    flit_vc_in       = '0;
    tail_sent_in     = 1'b0;
    credit_in        = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle of legal traffic; new packets only when allow_alloc is set.
  task automatic gen_cycle(input bit allow_alloc);
    logic [V-1:0] a, fv, c;
    logic         s, t;
    a = '0; fv = '0; c = '0; s = 1'b0; t = 1'b0;
    for (int v = 0; v < V; v++) begin
      if (pend[v] > 0 && $urandom_range(0, 2) == 0) begin
        c[v] = 1'b1;
        pend[v]--;
      end
    end
    if ($urandom_range(0, 3) != 0) begin
      int st;
      st = int'($urandom_range(0, V - 1));
      for (int i = 0; i < V; i++) begin
        int v;
        v = (st + i) % int'(V);
        // Credits seen upstream = B minus flits still in the downstream buffer.
        if (!s && rem[v] > 0 && (pend[v] + (c[v] ? 1 : 0)) < int'(B)) begin
          s      = 1'b1;
          fv[v]  = 1'b1;
          rem[v] = rem[v] - 1;
          t      = (rem[v] == 0);
          pend[v]++;
        end
      end
    end
    if (allow_alloc && $urandom_range(0, 2) == 0) begin
      int v;
      v = int'($urandom_range(0, V - 1));
      if (rem[v] == 0) begin
        a[v]   = 1'b1;
        rem[v] = int'($urandom_range(1, 6));
      end
    end
    apply(a, s, fv, t, c);
  endtask

  initial begin
    // Directed sequence from reset: {alloc, sent, vc, tail, credit, avb, asg, full, nf, err}
    tbl[0]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b1101, 4'b0010, 4'b0000, 4'b0010, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b1001, 4'b0110, 4'b0010, 4'b0100, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b1001, 4'b0110, 4'b0110, 4'b0000, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b1001, 4'b0110, 4'b0110, 4'b0000, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b1001, 4'b0110, 4'b0010, 4'b0100, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0100, 1'b1, 4'b0000, 4'b1001, 4'b0010, 4'b0110, 4'b0000, 1'b0};
    tbl[13] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1000, 4'b0011, 4'b0110, 4'b0000, 1'b0};
    tbl[14] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0000, 4'b1000, 4'b0011, 4'b0110, 4'b0000, 1'b0};
    tbl[15] = '{4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0000, 4'b1001, 4'b0010, 4'b0110, 4'b0000, 1'b0};

    rst();
    check("reset.avb", ovc_avb_out, 4'b1111);
    check("reset.asg", ovc_is_assigned_out, 4'b0000);
    check("reset.full", ovc_full_out, 4'b0000);
    check("reset.nf", ovc_nearly_full_out, 4'b0000);
    check1("reset.err", credit_err_out, 1'b0);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].alloc, tbl[i].sent, tbl[i].vc, tbl[i].tail, tbl[i].credit);
      check($sformatf("tbl%0d.avb", i), ovc_avb_out, tbl[i].avb);
      check($sformatf("tbl%0d.asg", i), ovc_is_assigned_out, tbl[i].asg);
      check($sformatf("tbl%0d.full", i), ovc_full_out, tbl[i].full);
      check($sformatf("tbl%0d.nf", i), ovc_nearly_full_out, tbl[i].nf);
      check1($sformatf("tbl%0d.err", i), credit_err_out, tbl[i].err);
    end

    // Credit overflow on VC3 holds the count at B.
    rst();
    apply('0, 1'b0, '0, 1'b0, 4'b1000);
    check1("ovf.err", credit_err_out, 1'b1);
    check("ovf.full", ovc_full_out, 4'b0000);
    apply(4'b1000, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) apply('0, 1'b1, 4'b1000, 1'b0, '0);
    check("ovf.held_nf", ovc_nearly_full_out, 4'b1000);
    idle(3);
    check1("ovf.sticky", credit_err_out, 1'b1);
    rst();
    check1("ovf.cleared", credit_err_out, 1'b0);

    // Flit on an unassigned VC.
    rst();
    apply('0, 1'b1, 4'b1000, 1'b0, '0);
    check1("unasg.err", credit_err_out, 1'b1);
    check("unasg.nf_cnt", ovc_full_out, 4'b0000);
    check_model("unasg");

    // Multi-hot flit VC with both VCs legitimately owned.
    rst();
    apply(4'b0010, 1'b0, '0, 1'b0, '0);
    apply(4'b0100, 1'b0, '0, 1'b0, '0);
    check1("mhvc.pre", credit_err_out, 1'b0);
    apply('0, 1'b1, 4'b0110, 1'b0, '0);
    check1("mhvc.err", credit_err_out, 1'b1);
    check_model("mhvc");

    // Multi-hot allocation.
    rst();
    apply(4'b0011, 1'b0, '0, 1'b0, '0);
    check1("mhalloc.err", credit_err_out, 1'b1);

    // Re-allocating an owned VC without a release.
    rst();
    apply(4'b0001, 1'b0, '0, 1'b0, '0);
    check1("realloc.pre", credit_err_out, 1'b0);
    apply(4'b0001, 1'b0, '0, 1'b0, '0);
    check1("realloc.err", credit_err_out, 1'b1);
    check("realloc.asg", ovc_is_assigned_out, 4'b0001);

    // Reset asserted mid-packet while other inputs are active.
    rst();
    apply(4'b0010, 1'b0, '0, 1'b0, '0);
    apply('0, 1'b1, 4'b0010, 1'b0, '0);
    apply('0, 1'b1, 4'b0010, 1'b0, '0);
    reset            = 1'b1;
    ovc_allocated_in = 4'b0100;
    flit_sent_in     = 1'b1;
    flit_vc_in       = 4'b0010;
    credit_in        = 4'b1001;
    @(posedge clk);
    #1;
    check("midrst.avb", ovc_avb_out, 4'b1111);
    check("midrst.asg", ovc_is_assigned_out, 4'b0000);
    check1("midrst.err", credit_err_out, 1'b0);
    reset = 1'b0;
    model_reset();
    idle(1);
    check_model("midrst.after");

    // Random legal traffic against the reference model.
    rst();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      gen_cycle(1'b1);
      check_model("rand");
      if (errors > 20) break;
    end
    begin
      bit drained;
      drained = 1'b0;
      for (int cyc = 0; cyc < 2000 && !drained; cyc++) begin
        gen_cycle(1'b0);
        check_model("drain");
        drained = 1'b1;
        for (int v = 0; v < V; v++) if (rem[v] != 0 || pend[v] != 0) drained = 1'b0;
        if (errors > 20) break;
      end
      checks++;
      if (!drained) begin
        errors++;
        $display("FAIL drain_timeout: got not drained expected drained at %0t", $time);
      end
    end
    check("final.avb", ovc_avb_out, 4'b1111);
    check("final.asg", ovc_is_assigned_out, 4'b0000);
    check("final.full", ovc_full_out, 4'b0000);
    check("final.nf", ovc_nearly_full_out, 4'b0000);
    check1("final.err", credit_err_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
